// File: rtl/seqdet_sched.sv
// Round-robin front end for one shared bit-serial sequence detector.
// A granted requester's word is shifted MSB-first into the detector after a
// one-cycle detector clear; detector Out pulses are counted and returned with
// a single-cycle done pulse tagged with the requester index.
module seqdet_sched #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int DRAIN = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N-1:0]                         req,
  input  logic [N*WIDTH-1:0]                   data,
  output logic [N-1:0]                         grant,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(N)-1:0]                 done_id,
  output logic [$clog2(WIDTH+DRAIN+1)-1:0]     match_cnt,
  output logic                                 det_reset,
  output logic                                 det_in,
  input  logic                                 det_out
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(WIDTH + DRAIN + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [IW-1:0]     ptr;
  logic [CW-1:0]     phase;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  sreg;
  logic              pick_vld;
  logic [IW-1:0]     pick_id;
  logic [IW-1:0]     scan_id;
  logic              sample;
  logic              take;

  // Counter increment; the counter is sized so it can never wrap within a frame.
  function automatic logic [CW-1:0] cnt_add(input logic [CW-1:0] c, input logic s);
    return c + CW'(s);
  endfunction

  // Round-robin search: first set req bit scanning upward from ptr+1, with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    scan_id  = '0;
    for (int j = 0; j < N; j++) begin
      scan_id = IW'((int'(ptr) + 1 + j) % N);
      if (!pick_vld && req[scan_id]) begin
        pick_vld = 1'b1;
        pick_id  = scan_id;
      end
    end
  end

  assign take   = (state == ST_IDLE) && pick_vld;
  // Detector output is stale on the first shift cycle (it still holds the clear).
  assign sample = det_out && (((state == ST_SHIFT) && (phase != '0)) || (state == ST_DRAIN));

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FSM next-state and per-state outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    det_in   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (pick_vld) state_nx = ST_CLEAR;
      end
      ST_CLEAR: state_nx = ST_SHIFT;
      ST_SHIFT: begin
        det_in = sreg[WIDTH-1];
        if (phase == LAST_SHIFT) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (phase == LAST_DRAIN) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Cycle index within SHIFT and DRAIN; restarts on every state change.
  always_ff @(posedge clock) begin
    if (!reset)                                               phase <= '0;
    else if (state != state_nx)                               phase <= '0;
    else if ((state == ST_SHIFT) || (state == ST_DRAIN))      phase <= phase + CW'(1);
  end

  // Arbitration results: grant, served index and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      grant   <= '0;
      done_id <= '0;
      ptr     <= IW'(N - 1);
    end else if (take) begin
      grant   <= N'(1) << pick_id;
      done_id <= pick_id;
      ptr     <= pick_id;
    end else if (state == ST_DONE) begin
      grant   <= '0;
    end
  end

  // Pattern word: latched once at grant, then shifted out MSB-first.
  always_ff @(posedge clock) begin
    if (take)                   sreg <= data[int'(pick_id)*WIDTH +: WIDTH];
    else if (state == ST_SHIFT) sreg <= {sreg[WIDTH-2:0], 1'b0};
  end

  // Match counter; the final sample is folded in as the result is published.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt       <= '0;
      match_cnt <= '0;
    end else begin
      if (take)        cnt <= '0;
      else if (sample) cnt <= cnt_add(cnt, 1'b1);
      if ((state == ST_DRAIN) && (state_nx == ST_DONE))
        match_cnt <= cnt_add(cnt, sample);
    end
  end

  // Detector reset: held through our own reset and for the CLEAR cycle.
  always_ff @(posedge clock) begin
    if (!reset) det_reset <= 1'b1;
    else        det_reset <= (state_nx == ST_CLEAR);
  end

endmodule

// File: tb/tb_seqdet_sched.sv
// Directed bench for seqdet_sched with a registered detector model.
module tb_seqdet_sched;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int DRAIN = 1;

  logic              clock;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*WIDTH-1:0] data;
  logic [N-1:0]      grant;
  logic              busy;
  logic              done;
  logic [1:0]        done_id;
  logic [3:0]        match_cnt;
  logic              det_reset;
  logic              det_in;
  logic              det_out;

  int n_cmp = 0;
  int n_err = 0;

  seqdet_sched #(.N(N), .WIDTH(WIDTH), .DRAIN(DRAIN)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt),
    .det_reset (det_reset),
    .det_in    (det_in),
    .det_out   (det_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared detector model: registers In, cleared by its reset.
  always @(posedge clock) begin
    if (det_reset) det_out <= 1'b0;
    else           det_out <= det_in;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Step until done (bounded), then check the frame result and latency.
  task automatic frame(input string tag, input int id, input int cnt, input int lat);
    int cyc;
    logic [N-1:0] g;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (done !== 1'b1 && cyc < 40);
    g = '0;
    g[id] = 1'b1;
    chk({tag, "_done"},  32'(done),      1);
    chk({tag, "_lat"},   32'(cyc),       32'(lat));
    chk({tag, "_id"},    32'(done_id),   32'(id));
    chk({tag, "_cnt"},   32'(match_cnt), 32'(cnt));
    chk({tag, "_grant"}, 32'(grant),     32'(g));
  endtask

  initial begin
    logic [7:0] w;
    reset = 1'b0;
    req   = '0;
    data  = '0;

    // Scenario 1: reset state and idle after release
    step();
    step();
    chk("rst_grant",   32'(grant),     0);
    chk("rst_busy",    32'(busy),      0);
    chk("rst_done",    32'(done),      0);
    chk("rst_detrst",  32'(det_reset), 1);
    chk("rst_detin",   32'(det_in),    0);
    chk("rst_id",      32'(done_id),   0);
    chk("rst_cnt",     32'(match_cnt), 0);
    reset = 1'b1;
    step();
    chk("idle_detrst", 32'(det_reset), 0);
    chk("idle_busy",   32'(busy),      0);
    step();
    step();
    chk("idle_busy2",  32'(busy),      0);
    chk("idle_grant",  32'(grant),     0);

    // Scenario 2: single frame, serial bit order and latency
    w = 8'hB5;
    data[7:0] = w;
    req = 4'b0001;
    for (int s = 1; s <= 12; s++) begin
      step();
      if (s == 1) begin
        chk("s2_clr_detrst", 32'(det_reset), 1);
        chk("s2_clr_grant",  32'(grant),     1);
        chk("s2_clr_busy",   32'(busy),      1);
        chk("s2_clr_detin",  32'(det_in),    0);
      end else if (s <= 9) begin
        chk("s2_bit",        32'(det_in),    32'(w[9-s]));
        chk("s2_detrst",     32'(det_reset), 0);
      end else if (s == 10) begin
        chk("s2_drain_detin", 32'(det_in),   0);
      end
      if (s < 11) chk("s2_nodone", 32'(done), 0);
      if (s == 11) begin
        chk("s2_done",  32'(done),      1);
        chk("s2_id",    32'(done_id),   0);
        chk("s2_cnt",   32'(match_cnt), 5);
        chk("s2_grant", 32'(grant),     1);
        req = '0;
      end
      if (s == 12) begin
        chk("s2_pulse", 32'(done),  0);
        chk("s2_gdrop", 32'(grant), 0);
        chk("s2_idle",  32'(busy),  0);
        chk("s2_hold",  32'(match_cnt), 5);
      end
    end

    // Scenario 3: fairness with all requesters held (pointer reset first)
    reset = 1'b0;
    step();
    reset = 1'b1;
    data = {8'h81, 8'h0F, 8'h00, 8'hFF};
    req  = 4'b1111;
    frame("s3_r0", 0, 8, 11);
    frame("s3_r1", 1, 0, 12);
    frame("s3_r2", 2, 4, 12);
    frame("s3_r3", 3, 2, 12);
    frame("s3_r0b", 0, 8, 12);
    req = '0;
    step();
    chk("s3_pulse", 32'(done), 0);

    // Scenario 4a: req[1] raised, req[2] dropped mid-frame, req[3] idle
    req = 4'b0100;
    step();
    step();
    step();
    req = 4'b0010;
    frame("s4_r2", 2, 4, 8);
    frame("s4_r1", 1, 0, 12);
    req = '0;
    step();

    // Scenario 4b: req[3] also pending -> served before req[1]
    req = 4'b0100;
    step();
    step();
    step();
    req = 4'b1010;
    frame("s4b_r2", 2, 4, 8);
    frame("s4b_r3", 3, 2, 12);
    req = 4'b0010;
    frame("s4b_r1", 1, 0, 12);
    req = '0;
    step();

    // Scenario 5: reset during SHIFT cycle 4 aborts without done
    data[7:0] = 8'hB5;
    req = 4'b0001;
    for (int s = 1; s <= 6; s++) step();
    chk("s5_busy", 32'(busy), 1);
    reset = 1'b0;
    step();
    chk("s5_busy0",   32'(busy),      0);
    chk("s5_grant0",  32'(grant),     0);
    chk("s5_nodone",  32'(done),      0);
    chk("s5_detrst",  32'(det_reset), 1);
    chk("s5_id0",     32'(done_id),   0);
    step();
    chk("s5_nodone2", 32'(done),      0);
    reset = 1'b1;
    frame("s5_rerun", 0, 5, 11);
    req = '0;
    step();

    // Scenario 6: data change after grant is ignored
    req = 4'b0001;
    step();
    data[7:0] = 8'h00;
    frame("s6_latched", 0, 5, 10);
    req = '0;
    step();
    chk("s6_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
